// File: rtl/layer_seq_pkg.sv
// Shared types and reset constants for the layer_seq sequencer.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic RST_NEURON_IN_VALID = 1'b0;
  localparam logic RST_OUT_VALID       = 1'b0;
  localparam logic RST_OUT_LAST        = 1'b0;
  localparam logic RST_TIMEOUT_ERR     = 1'b0;
  localparam logic RST_WORD_BIT        = 1'b0;

endpackage

// File: rtl/layer_seq_collect.sv
// Result collector: per-neuron capture slots, completion mask and read mux.
module layer_seq_collect #(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16,
  parameter int unsigned idxWidth   = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            capture_en,
  input  logic                            fill_zero,
  input  logic                            clear,
  input  logic [numNeurons*dataWidth-1:0] neuron_out,
  input  logic [numNeurons-1:0]           neuron_outvalid,
  input  logic [idxWidth-1:0]             rd_idx,
  output logic                            all_done_c,
  output logic [dataWidth-1:0]            rd_data
);

  logic [numNeurons-1:0] done_mask;
  logic [numNeurons-1:0] hit_c;
  logic [dataWidth-1:0]  res [numNeurons];

  // Only the first pulse per neuron inside WAIT is taken.
  assign hit_c      = capture_en ? (neuron_outvalid & ~done_mask) : '0;
  assign all_done_c = &(done_mask | hit_c);

  always_ff @(posedge clk) begin
    if (!rst)       done_mask <= '0;
    else if (clear) done_mask <= '0;
    else            done_mask <= done_mask | hit_c;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeurons; i++) begin
      if (!rst)                             res[i] <= '0;
      else if (hit_c[i])                    res[i] <= neuron_out[i*dataWidth +: dataWidth];
      else if (fill_zero && !done_mask[i])  res[i] <= '0;
    end
  end

  // Loop mux keeps unused index codes (non power-of-two counts) reading zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < numNeurons; i++) begin
      if (rd_idx == idxWidth'(i)) rd_data = res[i];
    end
  end

endmodule

// File: rtl/layer_seq.sv
// Layer sequencer: broadcasts the input vector to all neurons, then serialises their results.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int unsigned numInputs     = 784,
  parameter int unsigned numNeurons    = 30,
  parameter int unsigned dataWidth     = 16,
  parameter int unsigned timeoutCycles = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            weights_ready,
  input  logic [dataWidth-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [dataWidth-1:0]            neuron_in,
  output logic                            neuron_in_valid,
  input  logic [numNeurons*dataWidth-1:0] neuron_out,
  input  logic [numNeurons-1:0]           neuron_outvalid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int unsigned CNT_W = $clog2(numInputs + 1);
  localparam int unsigned IDX_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  if (timeoutCycles == 0) begin : g_cfg_check
    $error("layer_seq: timeoutCycles must be nonzero");
  end

  state_t               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 accept_c;
  logic                 out_fire_c;
  logic                 clear_c;
  logic                 all_done_c;
  logic                 timeout_c;
  logic [dataWidth-1:0] rd_data;

  // in_ready follows weights_ready combinationally so a withdrawn load stalls at once.
  assign in_ready   = (state == STREAM) && weights_ready;
  assign accept_c   = in_ready && in_valid;
  assign out_fire_c = out_valid_q && out_ready;
  assign clear_c    = out_fire_c && out_last_q;
  assign busy       = (state != IDLE);
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_valid_q ? rd_data : {dataWidth{RST_WORD_BIT}};

  layer_seq_collect #(
    .numNeurons (numNeurons),
    .dataWidth  (dataWidth),
    .idxWidth   (IDX_W)
  ) u_collect (
    .clk             (clk),
    .rst             (rst),
    .capture_en      (state == WAIT),
    .fill_zero       (timeout_c),
    .clear           (clear_c),
    .neuron_out      (neuron_out),
    .neuron_outvalid (neuron_outvalid),
    .rd_idx          (out_idx),
    .all_done_c      (all_done_c),
    .rd_data         (rd_data)
  );

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(timeoutCycles + 1);

  logic [TMO_W-1:0] wait_cnt;
  logic             timeout_q;

  // Fires on the last allowed WAIT cycle if some neuron is still missing.
  assign timeout_c   = (state == WAIT) && !all_done_c &&
                       (wait_cnt == TMO_W'(timeoutCycles - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= RST_TIMEOUT_ERR;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + 1'b1;
      if (timeout_c) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_c   = 1'b0;
  assign timeout_err = RST_TIMEOUT_ERR;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      in_cnt          <= '0;
      out_idx         <= '0;
      neuron_in       <= {dataWidth{RST_WORD_BIT}};
      neuron_in_valid <= RST_NEURON_IN_VALID;
      out_valid_q     <= RST_OUT_VALID;
      out_last_q      <= RST_OUT_LAST;
    end else begin
      neuron_in_valid <= 1'b0;
      if (accept_c) begin
        neuron_in       <= in_data;
        neuron_in_valid <= 1'b1;
        in_cnt          <= in_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (weights_ready) state <= STREAM;
        end
        STREAM: begin
          if (accept_c && (in_cnt == CNT_W'(numInputs - 1))) state <= WAIT;
        end
        WAIT: begin
          if (all_done_c || timeout_c) begin
            state       <= DRAIN;
            out_valid_q <= 1'b1;
            out_idx     <= '0;
            out_last_q  <= (numNeurons == 1);
          end
        end
        DRAIN: begin
          if (out_fire_c) begin
            if (out_last_q) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_idx     <= '0;
              in_cnt      <= '0;
            end else begin
              out_idx    <= out_idx + 1'b1;
              out_last_q <= (out_idx == IDX_W'(numNeurons - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
